// File: rtl/ahb_mas_arb.sv
// Two-requester AHB-Lite master: round-robin arbitration, SINGLE/INCR4 bursts, error abort.
// Define AHB_MAS_ARB_HWSTRB_EN to add the hwstrb byte-strobe output.
module ahb_mas_arb #(
   parameter int ADDRWIDTH = 32,
   parameter int DATAWIDTH = 32
) (
   input  logic                 hclk,
   input  logic                 hreset,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [ADDRWIDTH-1:0] req0_addr,
   input  logic                 req0_write,
   input  logic [2:0]           req0_size,
   input  logic                 req0_incr4,
   input  logic [DATAWIDTH-1:0] req0_wdata,
   output logic                 req0_wack,
   output logic                 rsp0_valid,
   output logic [DATAWIDTH-1:0] rsp0_data,
   output logic                 rsp0_done,
   output logic                 rsp0_err,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [ADDRWIDTH-1:0] req1_addr,
   input  logic                 req1_write,
   input  logic [2:0]           req1_size,
   input  logic                 req1_incr4,
   input  logic [DATAWIDTH-1:0] req1_wdata,
   output logic                 req1_wack,
   output logic                 rsp1_valid,
   output logic [DATAWIDTH-1:0] rsp1_data,
   output logic                 rsp1_done,
   output logic                 rsp1_err,
   output logic [ADDRWIDTH-1:0] haddr,
   output logic [1:0]           htrans,
   output logic [2:0]           hburst,
   output logic [2:0]           hsize,
   output logic                 hwrite,
   output logic [DATAWIDTH-1:0] hwdata,
`ifdef AHB_MAS_ARB_HWSTRB_EN
   output logic [DATAWIDTH/8-1:0] hwstrb,
`endif
   input  logic [DATAWIDTH-1:0] hrdata,
   input  logic                 hready,
   input  logic                 hresp,
   output logic [1:0]           dbg_state
);

   // Requester handshake: reqN_ready pulses in the single IDLE cycle a command is
   // taken; the command is latched then and reqN_valid is ignored until done.
   localparam logic [2:0] MAX_SIZE   = 3'($clog2(DATAWIDTH/8));
   localparam logic [1:0] TRANS_IDLE = 2'b00;
   localparam logic [1:0] TRANS_NSEQ = 2'b10;
   localparam logic [1:0] TRANS_SEQ  = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic                 gnt_q, last_q;
   logic [ADDRWIDTH-1:0] addr_q;
   logic                 write_q;
   logic [2:0]           size_q;
   logic                 incr4_q;
   logic [1:0]           beat_q;
   logic                 dph_q;

   logic grant, gnt_d, accept, dp_done, done, err;
   logic illegal, last_beat, wr_ack, rd_vld;
   logic [DATAWIDTH-1:0] wdata_sel;

   assign illegal   = (size_q > MAX_SIZE);
   assign last_beat = incr4_q ? (beat_q == 2'd3) : 1'b1;

   always_comb begin
      state_d = state_q;
      grant   = 1'b0;
      gnt_d   = gnt_q;
      accept  = 1'b0;
      dp_done = 1'b0;
      done    = 1'b0;
      err     = 1'b0;
      htrans  = TRANS_IDLE;
      case (state_q)
         S_IDLE: begin
            if (req0_valid || req1_valid) begin
               grant   = 1'b1;
               gnt_d   = (req0_valid && req1_valid) ? ~last_q : req1_valid;
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            if (illegal) begin
               done    = 1'b1;
               err     = 1'b1;
               state_d = S_IDLE;
            end else if (dph_q && hresp && !hready) begin
               state_d = S_ERR;
            end else begin
               htrans = (beat_q == 2'd0) ? TRANS_NSEQ : TRANS_SEQ;
               if (hready) begin
                  accept  = 1'b1;
                  dp_done = dph_q;
                  if (last_beat) state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (hresp && !hready) begin
               state_d = S_ERR;
            end else if (hready) begin
               dp_done = 1'b1;
               done    = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_ERR: begin
            if (hready) begin
               done    = 1'b1;
               err     = 1'b1;
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         state_q <= S_IDLE;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
         addr_q  <= '0;
         write_q <= 1'b0;
         size_q  <= 3'd0;
         incr4_q <= 1'b0;
         beat_q  <= 2'd0;
         dph_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (grant) begin
            gnt_q   <= gnt_d;
            last_q  <= gnt_d;
            addr_q  <= gnt_d ? req1_addr  : req0_addr;
            write_q <= gnt_d ? req1_write : req0_write;
            size_q  <= gnt_d ? req1_size  : req0_size;
            incr4_q <= gnt_d ? req1_incr4 : req0_incr4;
            beat_q  <= 2'd0;
         end else if (accept && !last_beat) begin
            beat_q <= beat_q + 2'd1;
            addr_q <= addr_q + (ADDRWIDTH'(1) << size_q);
         end
         // A data phase is outstanding from each address acceptance until the burst ends.
         if (accept) dph_q <= 1'b1;
         else if (state_d == S_IDLE || state_d == S_ERR) dph_q <= 1'b0;
      end
   end

   assign wdata_sel = gnt_q ? req1_wdata : req0_wdata;
   assign wr_ack    = dp_done && write_q;
   assign rd_vld    = dp_done && !write_q;

   assign haddr     = addr_q;
   assign hburst    = incr4_q ? 3'b011 : 3'b000;
   assign hsize     = size_q;
   assign hwrite    = write_q;
   assign hwdata    = (dph_q && write_q) ? wdata_sel : '0;
   assign dbg_state = state_q;

   assign req0_ready = grant && !hreset && !gnt_d;
   assign req1_ready = grant && !hreset && gnt_d;
   assign req0_wack  = wr_ack && !gnt_q;
   assign req1_wack  = wr_ack && gnt_q;
   assign rsp0_valid = rd_vld && !gnt_q;
   assign rsp1_valid = rd_vld && gnt_q;
   assign rsp0_data  = (rd_vld && !gnt_q) ? hrdata : '0;
   assign rsp1_data  = (rd_vld && gnt_q) ? hrdata : '0;
   assign rsp0_done  = done && !gnt_q;
   assign rsp1_done  = done && gnt_q;
   assign rsp0_err   = err && !gnt_q;
   assign rsp1_err   = err && gnt_q;

`ifdef AHB_MAS_ARB_HWSTRB_EN
   localparam int NBYTES = DATAWIDTH/8;
   logic [ADDRWIDTH-1:0] dp_addr_q;
   logic [ADDRWIDTH-1:0] dp_off;

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) dp_addr_q <= '0;
      else if (accept) dp_addr_q <= addr_q;
   end

   assign dp_off = dp_addr_q & ADDRWIDTH'(NBYTES-1);

   // Byte lane b is enabled when it lies in the same size-aligned block as the beat address.
   always_comb begin
      hwstrb = '0;
      if (dph_q && write_q) begin
         for (int b = 0; b < NBYTES; b++) begin
            hwstrb[b] = ((ADDRWIDTH'(b) >> size_q) == (dp_off >> size_q));
         end
      end
   end
`endif

endmodule

// File: tb/tb_ahb_mas_arb.sv
// Bench for ahb_mas_arb: directed scenarios plus random commands against a
// transaction-level model (beat addresses by arithmetic, slave data from a salted address).
module tb_ahb_mas_arb;
   localparam int AW = 32;
   localparam int DW = 32;

   logic          hclk;
   logic          hreset;
   logic [1:0]    req_valid;
   logic [AW-1:0] req_addr [2];
   logic [1:0]    req_write;
   logic [2:0]    req_size [2];
   logic [1:0]    req_incr4;
   logic [DW-1:0] req_wdata [2];
   logic          req0_ready, req1_ready, req0_wack, req1_wack;
   logic          rsp0_valid, rsp1_valid, rsp0_done, rsp1_done, rsp0_err, rsp1_err;
   logic [DW-1:0] rsp0_data, rsp1_data;
   logic [AW-1:0] haddr;
   logic [1:0]    htrans, dbg_state;
   logic [2:0]    hburst, hsize;
   logic          hwrite, hready, hresp;
   logic [DW-1:0] hwdata, hrdata;
   logic [1:0]    req_ready, req_wack, rsp_valid, rsp_done, rsp_err;

   int n_checks = 0;
   int n_fail   = 0;
   logic [1:0] grant_exp_q[$];
   logic [1:0] grant_got_q[$];

   assign req_ready = {req1_ready, req0_ready};
   assign req_wack  = {req1_wack, req0_wack};
   assign rsp_valid = {rsp1_valid, rsp0_valid};
   assign rsp_done  = {rsp1_done, rsp0_done};
   assign rsp_err   = {rsp1_err, rsp0_err};

   ahb_mas_arb #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) dut (
      .hclk(hclk), .hreset(hreset),
      .req0_valid(req_valid[0]), .req0_ready(req0_ready), .req0_addr(req_addr[0]),
      .req0_write(req_write[0]), .req0_size(req_size[0]), .req0_incr4(req_incr4[0]),
      .req0_wdata(req_wdata[0]), .req0_wack(req0_wack), .rsp0_valid(rsp0_valid),
      .rsp0_data(rsp0_data), .rsp0_done(rsp0_done), .rsp0_err(rsp0_err),
      .req1_valid(req_valid[1]), .req1_ready(req1_ready), .req1_addr(req_addr[1]),
      .req1_write(req_write[1]), .req1_size(req_size[1]), .req1_incr4(req_incr4[1]),
      .req1_wdata(req_wdata[1]), .req1_wack(req1_wack), .rsp1_valid(rsp1_valid),
      .rsp1_data(rsp1_data), .rsp1_done(rsp1_done), .rsp1_err(rsp1_err),
      .haddr(haddr), .htrans(htrans), .hburst(hburst), .hsize(hsize), .hwrite(hwrite),
      .hwdata(hwdata), .hrdata(hrdata), .hready(hready), .hresp(hresp),
      .dbg_state(dbg_state)
   );

   // Clock and watchdog
   initial begin
      hclk = 1'b0;
      forever #5 hclk = ~hclk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // One command from requester r. The bench plays the AHB slave: stall_beat forces one
   // hready=0 cycle while that address beat is presented, err_beat errors that data beat.
   task automatic do_cmd(input int r, input logic [31:0] a, input logic wr, input logic [2:0] sz,
                         input logic i4, input int stall_beat, input int err_beat, input bit rnd);
      logic [31:0] wb [4];
      logic [31:0] salt, step, paddr, ea, rd, other;
      logic [1:0]  onehot;
      int          nb, abeat, dbeat;
      bit          pend, err1, err2, stalled, finished, illegal, exp_done, exp_err, acc, comp;
      onehot  = 2'b01 << r;
      illegal = (sz > 3'd2);
      nb      = illegal ? 0 : (i4 ? 4 : 1);
      step    = 32'd1 << sz;
      foreach (wb[i]) wb[i] = $urandom;
      salt  = $urandom;
      paddr = 32'h0;
      ea    = 32'h0;
      abeat = 0; dbeat = 0;
      pend = 0; err1 = 0; err2 = 0; stalled = 0; finished = 0;
      @(posedge hclk); #1;
      req_valid[r] = 1'b1; req_addr[r] = a; req_write[r] = wr;
      req_size[r] = sz; req_incr4[r] = i4; req_wdata[r] = wb[0];
      hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
      #1;
      chk("grant_ready", req_ready, onehot);
      chk("grant_htrans", htrans, 2'b00);
      for (int c = 1; c <= 80 && !finished; c++) begin
         @(posedge hclk); #1;
         req_valid[r] = 1'b0;
         req_wdata[r] = wb[(dbeat < 4) ? dbeat : 3];
         hresp = 1'b0;
         if (err1) begin
            err2 = 1; hready = 1'b1; hresp = 1'b1;
         end else if (pend && dbeat == err_beat) begin
            err1 = 1; hready = 1'b0; hresp = 1'b1;
         end else if (abeat == stall_beat && !stalled) begin
            stalled = 1; hready = 1'b0;
         end else begin
            hready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
         end
         hrdata = pend ? (paddr ^ salt) : $urandom;
         #1;
         exp_done = 0; exp_err = 0; acc = 0; comp = 0;
         rd    = (r == 0) ? rsp0_data : rsp1_data;
         other = (r == 0) ? rsp1_data : rsp0_data;
         if (err2) begin
            exp_done = 1; exp_err = 1;
            chk("err_end_htrans", htrans, 2'b00);
         end else if (err1) begin
            chk("err_htrans", htrans, 2'b00);
         end else if (illegal) begin
            exp_done = (c == 1);
            exp_err  = exp_done;
            chk("illegal_htrans", htrans, 2'b00);
         end else begin
            if (abeat < nb) begin
               ea = a + 32'(abeat) * step;
               chk("haddr", haddr, ea);
               chk("htrans", htrans, (abeat == 0) ? 2'b10 : 2'b11);
               chk("hburst", hburst, i4 ? 3'b011 : 3'b000);
               chk("hsize", hsize, sz);
               chk("hwrite", hwrite, wr);
               acc = hready;
            end else begin
               chk("data_htrans", htrans, 2'b00);
            end
            if (pend && hready) begin
               comp = 1;
               if (wr) chk("hwdata", hwdata, wb[dbeat]);
               else    chk("rsp_data", rd, paddr ^ salt);
               dbeat++;
               exp_done = (dbeat == nb);
            end
         end
         chk("wack", req_wack, (comp && wr) ? onehot : 2'b00);
         chk("rsp_valid", rsp_valid, (comp && !wr) ? onehot : 2'b00);
         chk("rsp_done", rsp_done, exp_done ? onehot : 2'b00);
         chk("rsp_err", rsp_err, exp_err ? onehot : 2'b00);
         chk("other_data", other, 32'h0);
         if (comp) pend = 0;
         if (acc) begin
            pend = 1; paddr = ea; abeat++;
         end
         finished = exp_done;
      end
      chk("cmd_finished", finished, 1);
      chk("addr_beats", abeat, (err_beat >= 0 && err_beat < nb) ? err_beat + 1 : nb);
   endtask

   initial begin
      int rem0, rem1;
      hreset = 1'b1;
      hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
      for (int i = 0; i < 2; i++) begin
         req_addr[i]  = (i == 0) ? 32'h40 : 32'h80;
         req_size[i]  = 3'd2;
         req_wdata[i] = 32'h0;
      end
      req_valid = 2'b11; req_write = 2'b00; req_incr4 = 2'b00;

      // Reset values, with both requesters already asking
      repeat (3) @(posedge hclk);
      #1;
      chk("rst_htrans", htrans, 2'b00);
      chk("rst_haddr", haddr, 32'h0);
      chk("rst_hburst", hburst, 3'b000);
      chk("rst_hsize", hsize, 3'b000);
      chk("rst_hwrite", hwrite, 1'b0);
      chk("rst_hwdata", hwdata, 32'h0);
      chk("rst_ready", req_ready, 2'b00);
      chk("rst_wack", req_wack, 2'b00);
      chk("rst_valid", rsp_valid, 2'b00);
      chk("rst_done", rsp_done, 2'b00);
      chk("rst_err", rsp_err, 2'b00);
      chk("rst_state", dbg_state, 2'b00);

      // Round-robin: req0 has two commands, req1 one, all pending at reset exit
      grant_exp_q.push_back(2'd0);
      grant_exp_q.push_back(2'd1);
      grant_exp_q.push_back(2'd0);
      rem0 = 2; rem1 = 1;
      hreset = 1'b0;
      #1;
      for (int c = 0; c < 40 && grant_got_q.size() < 3; c++) begin
         if (c > 0) begin
            @(posedge hclk); #1;
            req_valid = {rem1 > 0, rem0 > 0};
            #1;
         end
         if (req_ready[0]) begin grant_got_q.push_back(2'd0); rem0--; end
         if (req_ready[1]) begin grant_got_q.push_back(2'd1); rem1--; end
      end
      @(posedge hclk); #1;
      req_valid = 2'b00;
      repeat (4) @(posedge hclk);
      chk("rr_count", grant_got_q.size(), grant_exp_q.size());
      foreach (grant_exp_q[i])
         chk("rr_order", (i < grant_got_q.size()) ? grant_got_q[i] : 2'd3, grant_exp_q[i]);

      // Directed scenarios
      do_cmd(0, 32'h0000_0100, 1'b1, 3'd2, 1'b0, -1, -1, 1'b0);
      do_cmd(1, 32'h0000_0200, 1'b0, 3'd2, 1'b1,  2, -1, 1'b0);
      do_cmd(0, 32'h0000_1000, 1'b1, 3'd2, 1'b1, -1,  1, 1'b0);
      do_cmd(0, 32'h0000_0040, 1'b0, 3'd3, 1'b0, -1, -1, 1'b0);
      do_cmd(1, 32'hFFFF_FFF8, 1'b0, 3'd2, 1'b1, -1, -1, 1'b0);
      do_cmd(0, 32'h0000_0021, 1'b1, 3'd0, 1'b1, -1, -1, 1'b0);
      do_cmd(1, 32'h0000_0032, 1'b1, 3'd1, 1'b1, -1,  3, 1'b0);

      // Reset in the middle of an INCR4 read
      @(posedge hclk); #1;
      req_valid[1] = 1'b1; req_addr[1] = 32'h300; req_write[1] = 1'b0;
      req_size[1] = 3'd2; req_incr4[1] = 1'b1; hready = 1'b1; hresp = 1'b0;
      @(posedge hclk); #1;
      req_valid[1] = 1'b0;
      #1;
      chk("mid_nonseq", htrans, 2'b10);
      @(posedge hclk); #1;
      hreset = 1'b1;
      #1;
      chk("mid_rst_htrans", htrans, 2'b00);
      chk("mid_rst_haddr", haddr, 32'h0);
      chk("mid_rst_done", rsp_done, 2'b00);
      chk("mid_rst_state", dbg_state, 2'b00);
      @(posedge hclk); #1;
      chk("mid_rst_done2", rsp_done, 2'b00);
      hreset = 1'b0;
      do_cmd(1, 32'h0000_0400, 1'b0, 3'd2, 1'b1, -1, -1, 1'b0);

      // Random commands with random wait states and occasional errors
      for (int k = 0; k < 24; k++) begin
         int r, eb;
         logic [2:0] sz;
         logic i4, wr;
         logic [31:0] a;
         r  = $urandom_range(0, 1);
         sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         i4 = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         a  = $urandom & ~((32'd1 << sz) - 32'd1);
         eb = ($urandom_range(0, 4) == 0) ? $urandom_range(0, i4 ? 3 : 0) : -1;
         do_cmd(r, a, wr, sz, i4, -1, eb, 1'b1);
      end

      repeat (2) @(posedge hclk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
